cpu_ctrl: RTL and testbench

Pipeline controller for the 5-stage CPU core. It generates the stall and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and resolves bus-busy stalls, load-use hazards, exceptions, interrupts, ERET and control-register writes. It owns the CPU control registers (status, EPC, exception cause, vector, interrupt mask). The instruction that has reached the MEM stage is the commit point.

---
 rtl/cpu_ctrl_pkg.sv | 39 +++
 rtl/cpu_ctrl_irq_sync.sv | 25 ++
 rtl/cpu_ctrl.sv | 141 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the pipeline controller: widths, control-register map,
// CTRL_OP codes, exception codes and STATUS bit positions.
package cpu_ctrl_pkg;

  localparam int PC_W    = 30;
  localparam int DATA_W  = 32;
  localparam int CREG_AW = 5;
  localparam int IRQ_W   = 8;
  localparam int EXP_W   = 3;

  localparam logic [CREG_AW-1:0] CREG_STATUS     = 5'd0;
  localparam logic [CREG_AW-1:0] CREG_PRE_STATUS = 5'd1;
  localparam logic [CREG_AW-1:0] CREG_EXP_VECTOR = 5'd2;
  localparam logic [CREG_AW-1:0] CREG_CAUSE      = 5'd3;
  localparam logic [CREG_AW-1:0] CREG_INT_MASK   = 5'd4;
  localparam logic [CREG_AW-1:0] CREG_IRQ_PEND   = 5'd5;
  localparam logic [CREG_AW-1:0] CREG_EPC        = 5'd6;

  typedef enum logic [1:0] {
    CTRL_OP_NOP  = 2'd0,
    CTRL_OP_WRCR = 2'd1,
    CTRL_OP_EXRT = 2'd2
  } ctrl_op_e;

  localparam logic [EXP_W-1:0] EXP_NONE    = 3'd0;
  localparam logic [EXP_W-1:0] EXP_EXT_INT = 3'd1;

  localparam int ST_INT_EN   = 0;
  localparam int ST_EXE_MODE = 1;

  localparam logic [IRQ_W-1:0] INT_MASK_RST = 8'hFF;

  // Bit 3 = IF/ID, 2 = ID/EX, 1 = EX/MEM, 0 = MEM/WB.
  typedef struct packed {
    logic [3:0] stall;
    logic [3:0] flush;
  } pipe_ctl_t;

endpackage

// File: rtl/cpu_ctrl_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt lines.
module irq_sync
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IRQ_W-1:0] d_i,
  output logic [IRQ_W-1:0] q_o
);

  logic [IRQ_W-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cpu_ctrl.sv
// Pipeline stall/flush controller and CPU control registers; commit point is MEM.
// Optional feature macro: CTRL_IRQ_EN (external interrupt path, INT_MASK, IRQ_PEND).
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               if_busy,
  input  logic               mem_busy,
  input  logic               ld_hazard,
  input  logic [PC_W-1:0]    mem_pc,
  input  logic               mem_en,
  input  logic [1:0]         mem_ctrl_op,
  input  logic [CREG_AW-1:0] mem_dst_addr,
  input  logic [DATA_W-1:0]  mem_wr_data,
  input  logic [EXP_W-1:0]   mem_exp_code,
  input  logic [IRQ_W-1:0]   irq,
  input  logic [CREG_AW-1:0] creg_rd_addr,
  output logic [DATA_W-1:0]  creg_rd_data,
  output logic               if_stall,
  output logic               id_stall,
  output logic               ex_stall,
  output logic               mem_stall,
  output logic               if_flush,
  output logic               id_flush,
  output logic               ex_flush,
  output logic               mem_flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               exe_mode,
  output logic               int_en
);

  logic [1:0]       status_q, status_d, pre_q, pre_d;
  logic [PC_W-1:0]  vec_q, vec_d, epc_q, epc_d;
  logic [EXP_W-1:0] cause_q, cause_d;
  logic [IRQ_W-1:0] mask_q, irq_pend;
  logic             irq_hit, mask_wr;
  pipe_ctl_t        ctl;

`ifdef CTRL_IRQ_EN
  logic [IRQ_W-1:0] mask_d;

  irq_sync u_irq_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (irq),
    .q_o   (irq_pend)
  );

  assign irq_hit = |(irq_pend & ~mask_q);
  assign mask_d  = mask_wr ? mem_wr_data[IRQ_W-1:0] : mask_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= INT_MASK_RST;
    else        mask_q <= mask_d;
  end
`else
  logic unused_irq;
  assign unused_irq = ^{irq, mask_wr};
  assign irq_pend   = '0;
  assign mask_q     = '0;
  assign irq_hit    = 1'b0;
`endif

  // Priority chain: busy > exception > interrupt > EXRT > WRCR > load-use.
  always_comb begin
    ctl      = '0;
    new_pc   = '0;
    mask_wr  = 1'b0;
    status_d = status_q;
    pre_d    = pre_q;
    vec_d    = vec_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    if (!reset) begin
      ctl = '0;
    end else if (if_busy || mem_busy) begin
      ctl.stall = '1;
    end else if (mem_en && ((mem_exp_code != EXP_NONE) || (status_q[ST_INT_EN] && irq_hit))) begin
      ctl.flush = '1;
      new_pc    = vec_q;
      epc_d     = mem_pc;
      cause_d   = (mem_exp_code != EXP_NONE) ? mem_exp_code : EXP_EXT_INT;
      pre_d     = status_q;
      status_d  = '0;
    end else if (mem_en && mem_ctrl_op == CTRL_OP_EXRT) begin
      ctl.flush = '1;
      new_pc    = epc_q;
      status_d  = pre_q;
    end else if (mem_en && mem_ctrl_op == CTRL_OP_WRCR) begin
      ctl.flush = '1;
      new_pc    = mem_pc + 30'd1;
      case (mem_dst_addr)
        CREG_STATUS:     status_d = mem_wr_data[1:0];
        CREG_PRE_STATUS: pre_d    = mem_wr_data[1:0];
        CREG_EXP_VECTOR: vec_d    = mem_wr_data[DATA_W-1:2];
        CREG_INT_MASK:   mask_wr  = 1'b1;
        default: ;
      endcase
    end else if (ld_hazard) begin
      ctl.stall[3] = 1'b1;
      ctl.flush[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_q <= '0;
      pre_q    <= '0;
      vec_q    <= '0;
      epc_q    <= '0;
      cause_q  <= '0;
    end else begin
      status_q <= status_d;
      pre_q    <= pre_d;
      vec_q    <= vec_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    creg_rd_data = '0;
    case (creg_rd_addr)
      CREG_STATUS:     creg_rd_data = {30'b0, status_q};
      CREG_PRE_STATUS: creg_rd_data = {30'b0, pre_q};
      CREG_EXP_VECTOR: creg_rd_data = {vec_q, 2'b00};
      CREG_CAUSE:      creg_rd_data = {29'b0, cause_q};
      CREG_INT_MASK:   creg_rd_data = {24'b0, mask_q};
      CREG_IRQ_PEND:   creg_rd_data = {24'b0, irq_pend};
      CREG_EPC:        creg_rd_data = {epc_q, 2'b00};
      default:         creg_rd_data = '0;
    endcase
  end

  assign {if_stall, id_stall, ex_stall, mem_stall} = ctl.stall;
  assign {if_flush, id_flush, ex_flush, mem_flush} = ctl.flush;
  assign exe_mode = status_q[ST_EXE_MODE];
  assign int_en   = status_q[ST_INT_EN];

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: drivers queue hand-computed expectations,
// a negedge monitor pops them and compares against the DUT outputs.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_busy, mem_busy, ld_hazard, mem_en;
  logic [29:0] mem_pc, new_pc;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr, creg_rd_addr;
  logic [31:0] mem_wr_data, creg_rd_data;
  logic [2:0]  mem_exp_code;
  logic [7:0]  irq;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic        exe_mode, int_en;

  cpu_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .ld_hazard(ld_hazard), .mem_pc(mem_pc), .mem_en(mem_en),
    .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
    .mem_wr_data(mem_wr_data), .mem_exp_code(mem_exp_code), .irq(irq),
    .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .exe_mode(exe_mode), .int_en(int_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  s;
    logic [3:0]  f;
    logic [29:0] npc;
    logic [31:0] rd;
    logic        em;
    logic        ie;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] irq_v = 8'h00;
  logic       rst_v = 1'b0;

`ifdef CTRL_IRQ_EN
  localparam logic [31:0] MASK_RST = 32'hFF;
`else
  localparam logic [31:0] MASK_RST = 32'h0;
`endif
  localparam logic [3:0] ALL = 4'b1111;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] gs, gf;
      e  = exp_q.pop_front();
      gs = {if_stall, id_stall, ex_stall, mem_stall};
      gf = {if_flush, id_flush, ex_flush, mem_flush};
      checks++;
      if ({gs, gf, new_pc, creg_rd_data, exe_mode, int_en} !==
          {e.s, e.f, e.npc, e.rd, e.em, e.ie}) begin
        errors++;
        $display("FAIL %s: got s=%b f=%b npc=%h rd=%h em=%b ie=%b, expected s=%b f=%b npc=%h rd=%h em=%b ie=%b",
                 e.name, gs, gf, new_pc, creg_rd_data, exe_mode, int_en,
                 e.s, e.f, e.npc, e.rd, e.em, e.ie);
      end
    end
  end

  // One vector: advance past the edge, drive inputs, queue the expectation.
  task automatic v(input string name, input logic ifb, input logic memb, input logic ld,
                   input logic en, input logic [1:0] op, input logic [4:0] dst,
                   input logic [31:0] data, input logic [29:0] pc, input logic [2:0] code,
                   input logic [4:0] raddr, input logic [3:0] s, input logic [3:0] f,
                   input logic [29:0] npc, input logic [31:0] rd, input logic em, input logic ie);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst_v; irq = irq_v;
    if_busy = ifb; mem_busy = memb; ld_hazard = ld; mem_en = en;
    mem_ctrl_op = op; mem_dst_addr = dst; mem_wr_data = data; mem_pc = pc;
    mem_exp_code = code; creg_rd_addr = raddr;
    e.name = name; e.s = s; e.f = f; e.npc = npc; e.rd = rd; e.em = em; e.ie = ie;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; irq = '0; if_busy = 0; mem_busy = 0; ld_hazard = 0; mem_en = 0;
    mem_ctrl_op = 0; mem_dst_addr = 0; mem_wr_data = 0; mem_pc = 0;
    mem_exp_code = 0; creg_rd_addr = 0;

    v("rst_state", 0,0,0,0,0,0,0,0,0, 4, 0,0,0, MASK_RST,0,0);
    rst_v = 1'b1;
    v("idle",      0,0,0,0,0,0,0,0,0, 0, 0,0,0, 0,0,0);
    v("ld_use",    0,0,1,0,0,0,0,0,0, 0, 4'b1000,4'b0100,0, 0,0,0);
    v("ld_busy",   0,1,1,0,0,0,0,0,0, 0, ALL,0,0, 0,0,0);
    v("wr_vec",    0,0,0,1,1,2,32'h100,30'h10,0, 2, 0,ALL,30'h11, 0,0,0);
    v("rd_vec",    0,0,0,0,0,0,0,0,0, 2, 0,0,0, 32'h100,0,0);
    v("wr_stat",   0,0,0,1,1,0,32'h3,30'h20,0, 0, 0,ALL,30'h21, 0,0,0);
    v("rd_stat",   0,0,0,0,0,0,0,0,0, 0, 0,0,0, 32'h3,1,1);
    v("busy_exc",  1,0,0,1,0,0,0,30'h100,4, 6, ALL,0,0, 0,1,1);
    v("exc",       0,0,1,1,1,2,32'hFFFFFFFF,30'h100,4, 6, 0,ALL,30'h40, 0,1,1);
    v("rd_epc",    0,0,0,0,0,0,0,0,0, 6, 0,0,0, 32'h400,0,0);
    v("rd_cause",  0,0,0,0,0,0,0,0,0, 3, 0,0,0, 32'h4,0,0);
    v("rd_pre",    0,0,0,0,0,0,0,0,0, 1, 0,0,0, 32'h3,0,0);
    v("rd_vec2",   0,0,0,0,0,0,0,0,0, 2, 0,0,0, 32'h100,0,0);
    v("eret",      0,0,0,1,2,0,0,30'h7,0, 0, 0,ALL,30'h100, 0,0,0);
    v("rd_stat2",  0,0,0,0,0,0,0,0,0, 0, 0,0,0, 32'h3,1,1);
    v("wr_wrap",   0,0,0,1,1,2,32'h200,30'h3FFFFFFF,0, 2, 0,ALL,30'h0, 32'h100,1,1);
    v("rd_vec3",   0,0,0,0,0,0,0,0,0, 2, 0,0,0, 32'h200,1,1);
    v("wr_ro",     0,0,0,1,1,3,32'h7,30'h5,0, 3, 0,ALL,30'h6, 32'h4,1,1);
    v("rd_cause2", 0,0,0,0,0,0,0,0,0, 3, 0,0,0, 32'h4,1,1);
    v("wr_bad",    0,0,0,1,1,9,32'hDEADBEEF,30'h0,0, 9, 0,ALL,30'h1, 0,1,1);
    v("no_en",     0,0,0,0,2,0,0,30'h9,4, 0, 0,0,0, 32'h3,1,1);
`ifdef CTRL_IRQ_EN
    v("wr_mask",   0,0,0,1,1,4,32'hFE,30'h50,0, 4, 0,ALL,30'h51, 32'hFF,1,1);
    irq_v = 8'h01;
    v("irq_t0",    0,0,0,1,0,0,0,30'h60,0, 5, 0,0,0, 0,1,1);
    v("irq_t1",    0,0,0,1,0,0,0,30'h60,0, 5, 0,0,0, 0,1,1);
    v("irq_t2",    0,0,0,1,0,0,0,30'h60,0, 5, 0,ALL,30'h80, 32'h1,1,1);
    v("irq_cause", 0,0,0,1,0,0,0,30'h61,0, 3, 0,0,0, 32'h1,0,0);
    v("wr_maskff", 0,0,0,1,1,4,32'hFF,30'h62,0, 4, 0,ALL,30'h63, 32'hFE,0,0);
    v("eret_irq",  0,0,0,1,2,0,0,30'h0,0, 6, 0,ALL,30'h60, 32'h180,0,0);
    v("irq_masked",0,0,0,1,0,0,0,30'h64,0, 5, 0,0,0, 32'h1,1,1);
    irq_v = 8'h00;
`else
    irq_v = 8'hFF;
    v("irq_ign0",  0,0,0,1,0,0,0,30'h60,0, 5, 0,0,0, 0,1,1);
    v("irq_ign1",  0,0,0,1,0,0,0,30'h60,0, 5, 0,0,0, 0,1,1);
    v("irq_ign2",  0,0,0,1,0,0,0,30'h60,0, 5, 0,0,0, 0,1,1);
    v("wr_mask_x", 0,0,0,1,1,4,32'hFF,30'h62,0, 4, 0,ALL,30'h63, 0,1,1);
    v("rd_mask_x", 0,0,0,0,0,0,0,0,0, 4, 0,0,0, 0,1,1);
    irq_v = 8'h00;
`endif
    rst_v = 1'b0;
    v("rst_mid",   1,0,0,1,0,0,0,30'h100,4, 0, 0,0,0, 0,0,0);
    v("rst_mask",  0,0,0,0,0,0,0,0,0, 4, 0,0,0, MASK_RST,0,0);
    rst_v = 1'b1;
    v("rst_vec",   0,0,0,0,0,0,0,0,0, 2, 0,0,0, 0,0,0);
    v("rst_epc",   0,0,0,0,0,0,0,0,0, 6, 0,0,0, 0,0,0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
